// File: rtl/gray_counter_if.sv
// Handshake and data bundle for gray_counter.
// master is the counter side; slave is the downstream consumer/driver side.
interface gray_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             wrap;

  modport master (
    input  en, up_down, load, load_val, out_ready,
    output out_valid, gray_out, bin_out, wrap
  );

  modport slave (
    output en, up_down, load, load_val, out_ready,
    input  out_valid, gray_out, bin_out, wrap
  );
endinterface

// File: rtl/gray_counter.sv
// Registered up/down Gray-code generator with a valid/ready output stage.
// GRAY_CNT_SATURATE_EN: boundary steps hold the count instead of wrapping.
module gray_counter #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  gray_counter_if.master bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             slot_free;
  logic             boundary;
  logic [WIDTH-1:0] bin_step;

  always_comb begin
    slot_free = !valid_q || bus.out_ready;
    boundary  = bus.up_down ? (bin_q == {WIDTH{1'b1}}) : (bin_q == '0);
    bin_step  = bus.up_down ? (bin_q + ONE) : (bin_q - ONE);

    bin_d   = bin_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;

    if (bus.load) begin
      bin_d   = bus.load_val;
      valid_d = 1'b1;
    end else if (bus.en && slot_free) begin
      valid_d = 1'b1;
      wrap_d  = boundary;
`ifdef GRAY_CNT_SATURATE_EN
      bin_d   = boundary ? bin_q : bin_step;
`else
      bin_d   = bin_step;
`endif
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end

    // Gray word is derived from the next binary value so both register together.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q   <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.bin_out   = bin_q;
  assign bus.gray_out  = gray_q;
  assign bus.out_valid = valid_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed vector table plus hand-written sequences for gray_counter (WIDTH=8).
module tb_gray_counter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  gray_counter_if #(.WIDTH(8)) bus ();

  gray_counter #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       en;
    logic       up;
    logic       rdy;
    logic       ev;
    logic [7:0] eb;
    logic [7:0] eg;
    logic       ew;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, got, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [7:0] lv, input logic en,
                       input logic up, input logic rdy);
    bus.load      = ld;
    bus.load_val  = lv;
    bus.en        = en;
    bus.up_down   = up;
    bus.out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] model;
    logic [7:0] prev_gray;
    logic [7:0] diff;
    logic       exp_wrap;
    int         wraps;

    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    //           ld  lv     en  up  rdy  ev  bin    gray   wrap
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 8'h03, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02, 8'h03, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 1'b0};
    vecs[6]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h77, 1'b0};
    vecs[7]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
`ifdef GRAY_CNT_SATURATE_EN
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
`else
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h80, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h80, 1'b0};
`endif
    vecs[10] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 8'h18, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 8'h08, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 8'h18, 1'b0};
    vecs[13] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h80, 1'b0};
`ifdef GRAY_CNT_SATURATE_EN
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h80, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h80, 1'b0};
`else
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
`endif

    // Reset state
    do_reset();
    chk("rst_valid", {7'b0, bus.out_valid}, 8'h00);
    chk("rst_bin",   bus.bin_out,  8'h00);
    chk("rst_gray",  bus.gray_out, 8'h00);
    chk("rst_wrap",  {7'b0, bus.wrap}, 8'h00);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].up, vecs[i].rdy);
      tick();
      chk($sformatf("v%0d_valid", i), {7'b0, bus.out_valid}, {7'b0, vecs[i].ev});
      chk($sformatf("v%0d_bin", i),   bus.bin_out,  vecs[i].eb);
      chk($sformatf("v%0d_gray", i),  bus.gray_out, vecs[i].eg);
      chk($sformatf("v%0d_wrap", i),  {7'b0, bus.wrap}, {7'b0, vecs[i].ew});
    end

    // Full up sweep from reset: one-bit changes and a single wrap pulse
    do_reset();
    model     = 8'h00;
    prev_gray = 8'h00;
    wraps     = 0;
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 256; i++) begin
      exp_wrap = (model == 8'hFF);
`ifdef GRAY_CNT_SATURATE_EN
      if (model != 8'hFF) model = model + 8'h01;
`else
      model = model + 8'h01;
`endif
      tick();
      chk($sformatf("sweep%0d_bin", i),  bus.bin_out,  model);
      chk($sformatf("sweep%0d_gray", i), bus.gray_out, model ^ (model >> 1));
      chk($sformatf("sweep%0d_wrap", i), {7'b0, bus.wrap}, {7'b0, exp_wrap});
      if (bus.wrap) wraps++;
      if (!exp_wrap || model != prev_gray) begin
        diff = bus.gray_out ^ prev_gray;
`ifndef GRAY_CNT_SATURATE_EN
        chk($sformatf("sweep%0d_onebit", i), 8'($countones(diff)), 8'd1);
`else
        if (!exp_wrap) chk($sformatf("sweep%0d_onebit", i), 8'($countones(diff)), 8'd1);
`endif
      end
      prev_gray = bus.gray_out;
    end
    chk("sweep_first_gray_after", 8'(wraps), 8'd1);

    // Stall with en held, then release: one step per cycle, none skipped
    drive(1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d_bin", i),   bus.bin_out, 8'h20);
      chk($sformatf("stall%0d_valid", i), {7'b0, bus.out_valid}, 8'h01);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("release%0d_bin", i), bus.bin_out, 8'(8'h20 + i));
    end

    // Asynchronous reset mid-stream, then restart from zero
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {7'b0, bus.out_valid}, 8'h00);
    chk("arst_bin",   bus.bin_out,  8'h00);
    chk("arst_gray",  bus.gray_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    chk("restart_down_bin",  bus.bin_out,  8'hFF);
    chk("restart_down_gray", bus.gray_out, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
